// File: rtl/bram_capture_writer_pkg.sv
// Shared definitions for the BRAM capture writer: flush FSM encoding and default widths
// that match the waveform readout block.
package bram_capture_writer_pkg;

    localparam int DEFAULT_WORD_WID      = 24;
    localparam int DEFAULT_WORD_AMNT_WID = 11;
    localparam int DEFAULT_WORD_AMNT     = 2047;
    localparam int DEFAULT_RAM_WID       = 32;
    localparam int DEFAULT_RAM_WORD_WID  = 16;
    localparam int DEFAULT_RAM_WORD_INCR = 2;

    typedef enum logic [1:0] {
        IDLE                   = 2'd0,
        WRITE_LOW              = 2'd1,
        WRITE_HIGH             = 2'd2,
        WAIT_ON_FLUSH_DEASSERT = 2'd3
    } flush_state_t;

endpackage

// File: rtl/capture_buffer_ram.sv
// Simple dual-port backing buffer for captured samples: one write port, one registered read port.
module capture_buffer_ram #(
    parameter int DATA_WID = 24,
    parameter int ADDR_WID = 11,
    parameter int DEPTH    = 2048
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_WID-1:0] wr_addr,
    input  logic [DATA_WID-1:0] wr_data,
    input  logic [ADDR_WID-1:0] rd_addr,
    output logic [DATA_WID-1:0] rd_data
);

    logic [DATA_WID-1:0] mem [DEPTH];

    // Contents are deliberately not reset; only the capture count says what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bram_capture_writer.sv
// Captures producer samples into a local buffer and DMA-writes them to RAM as low/high halves.
// Define BRAM_CAPTURE_SIGN_EXTEND_EN to sign-extend the high half instead of zero-extending it.
module bram_capture_writer
    import bram_capture_writer_pkg::*;
#(
    parameter int WORD_WID      = DEFAULT_WORD_WID,
    parameter int WORD_AMNT_WID = DEFAULT_WORD_AMNT_WID,
    parameter int WORD_AMNT     = DEFAULT_WORD_AMNT,
    parameter int RAM_WID       = DEFAULT_RAM_WID,
    parameter int RAM_WORD_WID  = DEFAULT_RAM_WORD_WID,
    parameter int RAM_WORD_INCR = DEFAULT_RAM_WORD_INCR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_WID-1:0]      word,
    input  logic                     word_strobe,
    output logic                     word_ack,
    output logic                     word_full,
    output logic [WORD_AMNT_WID:0]   word_count,
    input  logic                     flush_start,
    input  logic [RAM_WID-1:0]       start_addr,
    output logic                     flush_finished,
    output logic [RAM_WID-1:0]       ram_dma_addr,
    output logic [RAM_WORD_WID-1:0]  ram_word,
    output logic                     ram_write,
    input  logic                     ram_done
);

    localparam int CW = WORD_AMNT_WID + 1;

    flush_state_t             state, state_next;
    logic [CW-1:0]            word_count_next;
    logic                     word_ack_next;
    logic                     flush_finished_next;
    logic [RAM_WID-1:0]       ram_dma_addr_next;
    logic                     ram_write_next;
    logic [WORD_AMNT_WID-1:0] flush_idx, flush_idx_next;
    logic                     read_ready, read_ready_next;
    logic                     buf_we;
    logic [WORD_WID-1:0]      rd_data;
    logic [RAM_WORD_WID-1:0]  high_half;

    capture_buffer_ram #(
        .DATA_WID (WORD_WID),
        .ADDR_WID (WORD_AMNT_WID),
        .DEPTH    (WORD_AMNT + 1)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (word_count[WORD_AMNT_WID-1:0]),
        .wr_data (word),
        .rd_addr (flush_idx),
        .rd_data (rd_data)
    );

    assign word_full = (word_count == CW'(WORD_AMNT + 1));

    always_comb begin
`ifdef BRAM_CAPTURE_SIGN_EXTEND_EN
        high_half = RAM_WORD_WID'($signed(rd_data[WORD_WID-1:RAM_WORD_WID]));
`else
        high_half = RAM_WORD_WID'(rd_data[WORD_WID-1:RAM_WORD_WID]);
`endif
    end

    // ram_word is only meaningful while ram_write is high; held at zero otherwise.
    always_comb begin
        ram_word = '0;
        if (ram_write) begin
            ram_word = (state == WRITE_HIGH) ? high_half : rd_data[RAM_WORD_WID-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            word_count     <= '0;
            word_ack       <= 1'b0;
            flush_finished <= 1'b0;
            ram_dma_addr   <= '0;
            ram_write      <= 1'b0;
            flush_idx      <= '0;
            read_ready     <= 1'b0;
        end else begin
            state          <= state_next;
            word_count     <= word_count_next;
            word_ack       <= word_ack_next;
            flush_finished <= flush_finished_next;
            ram_dma_addr   <= ram_dma_addr_next;
            ram_write      <= ram_write_next;
            flush_idx      <= flush_idx_next;
            read_ready     <= read_ready_next;
        end
    end

    // The first cycle in each WRITE_x state waits for the registered buffer read; a flush
    // request takes priority over a simultaneous strobe so the count cannot change under it.
    always_comb begin
        state_next          = state;
        word_count_next     = word_count;
        word_ack_next       = word_ack;
        flush_finished_next = flush_finished;
        ram_dma_addr_next   = ram_dma_addr;
        ram_write_next      = ram_write;
        flush_idx_next      = flush_idx;
        read_ready_next     = read_ready;
        buf_we              = 1'b0;

        case (state)
            IDLE: begin
                if (flush_start && !word_ack) begin
                    ram_dma_addr_next = start_addr;
                    flush_idx_next    = '0;
                    read_ready_next   = 1'b0;
                    state_next        = (word_count != '0) ? WRITE_LOW : WAIT_ON_FLUSH_DEASSERT;
                end else if (word_strobe && !word_ack && !word_full) begin
                    buf_we          = 1'b1;
                    word_count_next = word_count + CW'(1);
                    word_ack_next   = 1'b1;
                end else if (!word_strobe && word_ack) begin
                    word_ack_next = 1'b0;
                end
            end
            WRITE_LOW, WRITE_HIGH: begin
                if (!read_ready) begin
                    read_ready_next = 1'b1;
                    ram_write_next  = 1'b1;
                end else if (ram_write && ram_done) begin
                    ram_write_next    = 1'b0;
                    read_ready_next   = 1'b0;
                    ram_dma_addr_next = ram_dma_addr + RAM_WID'(RAM_WORD_INCR);
                    if (state == WRITE_LOW) begin
                        state_next = WRITE_HIGH;
                    end else if ({1'b0, flush_idx} == word_count - CW'(1)) begin
                        state_next = WAIT_ON_FLUSH_DEASSERT;
                    end else begin
                        flush_idx_next = flush_idx + WORD_AMNT_WID'(1);
                        state_next     = WRITE_LOW;
                    end
                end
            end
            WAIT_ON_FLUSH_DEASSERT: begin
                if (flush_start) begin
                    flush_finished_next = 1'b1;
                end else begin
                    flush_finished_next = 1'b0;
                    word_count_next     = '0;
                    state_next          = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
